// File: rtl/barrel_pkg.sv
// Shared op encodings and fill helper for the pipelined barrel shifter.
package barrel_pkg;

  localparam logic [2:0] OP_ROL = 3'd0;
  localparam logic [2:0] OP_ROR = 3'd1;
  localparam logic [2:0] OP_SLL = 3'd2;
  localparam logic [2:0] OP_SRL = 3'd3;
  localparam logic [2:0] OP_SRA = 3'd4;

  // Bit shifted in from the MSB side on a right shift: sign for SRA, zero otherwise.
  function automatic logic fill_bit(input logic [2:0] op, input logic msb);
    return (op == OP_SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline slice: conditional shift/rotate by 2^K, then a valid-qualified register.
module barrel_shift_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TAG_W   = 4,
  parameter int SHAMT_W = 3,
  parameter int K       = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               up_valid,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  logic [2:0]         up_op,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  output logic [SHAMT_W-1:0] shamt,
  output logic [2:0]         op,
  output logic [TAG_W-1:0]   tag
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] shifted;

  // Apply this stage's 2^K step when its amount bit is set; the MSB is the sign for SRA at every stage.
  always_comb begin
    ones    = '1;
    hi_mask = ~(ones >> S);
    shifted = up_data;
    if (up_shamt[K]) begin
      case (up_op)
        OP_ROL:         shifted = (up_data << S) | (up_data >> (WIDTH - S));
        OP_ROR:         shifted = (up_data >> S) | (up_data << (WIDTH - S));
        OP_SLL:         shifted = up_data << S;
        OP_SRL, OP_SRA: shifted = (up_data >> S) |
                                  (hi_mask & {WIDTH{fill_bit(up_op, up_data[WIDTH-1])}});
        default:        shifted = up_data;
      endcase
    end
  end

  // Register slice: advance only when the top says this stage may load; hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      shamt <= '0;
      op    <= '0;
      tag   <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data  <= shifted;
        shamt <= up_shamt;
        op    <= up_op;
        tag   <= up_tag;
      end
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: amount normalisation, log2(WIDTH) shift stages, valid/ready stall chain.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TAG_W   = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W:0]   in_shamt,
  input  logic [2:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int L = SHAMT_W;

  logic [L:0]         valid_s;
  logic [L:0]         rdy;
  logic [WIDTH-1:0]   data_s  [0:L];
  logic [SHAMT_W-1:0] shamt_s [0:L];
  logic [2:0]         op_s    [0:L];
  logic [TAG_W-1:0]   tag_s   [0:L];

  logic [WIDTH-1:0]   norm_data;
  logic [SHAMT_W-1:0] norm_shamt;

  // Fold out-of-range amounts into the data so the stages only ever see 0..WIDTH-1.
  always_comb begin
    norm_data  = in_data;
    norm_shamt = '0;
    case (in_op)
      OP_ROL, OP_ROR: norm_shamt = in_shamt[SHAMT_W-1:0];
      OP_SLL, OP_SRL: begin
        if (in_shamt[SHAMT_W]) norm_data  = '0;
        else                   norm_shamt = in_shamt[SHAMT_W-1:0];
      end
      OP_SRA: begin
        if (in_shamt[SHAMT_W]) norm_data  = {WIDTH{in_data[WIDTH-1]}};
        else                   norm_shamt = in_shamt[SHAMT_W-1:0];
      end
      default: ;
    endcase
  end

  // Ready chain from the output back: an empty stage always loads, so bubbles collapse.
  always_comb begin
    rdy    = '0;
    rdy[L] = out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      rdy[k] = !valid_s[k+1] || rdy[k+1];
    end
  end

  assign valid_s[0] = in_valid;
  assign data_s[0]  = norm_data;
  assign shamt_s[0] = norm_shamt;
  assign op_s[0]    = in_op;
  assign tag_s[0]   = in_tag;

  for (genvar k = 0; k < L; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH   (WIDTH),
      .TAG_W   (TAG_W),
      .SHAMT_W (SHAMT_W),
      .K       (k)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .load     (rdy[k]),
      .up_valid (valid_s[k]),
      .up_data  (data_s[k]),
      .up_shamt (shamt_s[k]),
      .up_op    (op_s[k]),
      .up_tag   (tag_s[k]),
      .valid    (valid_s[k+1]),
      .data     (data_s[k+1]),
      .shamt    (shamt_s[k+1]),
      .op       (op_s[k+1]),
      .tag      (tag_s[k+1])
    );
  end

  // The last stage's control fields have no consumer.
  logic unused_tail;
  assign unused_tail = ^{shamt_s[L], op_s[L]};

  assign in_ready  = rdy[0];
  assign out_valid = valid_s[L];
  assign out_data  = data_s[L];
  assign out_tag   = tag_s[L];

endmodule
